// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the rggen bus fabric.
// Access/status encodings match the existing register-block adapters.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic {
        RGGEN_ARB_IDLE = 1'b0,
        RGGEN_ARB_BUSY = 1'b1
    } rggen_arb_state;

    // Index width that never collapses to zero bits.
    function automatic int rggen_clog2_min1(int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Request/response bus between bridges, arbiter and register block.
// The master drives the request; the slave answers with ready/status/data.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid,
        output access,
        output address,
        output write_data,
        output strobe,
        input  ready,
        input  status,
        input  read_data
    );

    modport slave (
        input  valid,
        input  access,
        input  address,
        input  write_data,
        input  strobe,
        output ready,
        output status,
        output read_data
    );

endinterface

// File: rtl/rggen_mux.sv
// One-hot AND-OR multiplexer.
// Output is zero when no select bit is set.
module rggen_mux #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 2
)(
    input  logic [ENTRIES-1:0] i_select,
    input  logic [WIDTH-1:0]   i_data [ENTRIES],
    output logic [WIDTH-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            o_data = o_data | ({WIDTH{i_select[i]}} & i_data[i]);
        end
    end

endmodule

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin (or fixed-priority) one-hot grant.
// Requests are doubled, rotated past the last winner and priority-encoded.
module rggen_round_robin_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter  int HOSTS          = 2,
    parameter  bit FIXED_PRIORITY = 1'b0,
    localparam int IDX_W          = rggen_clog2_min1(HOSTS)
)(
    input  logic [HOSTS-1:0] i_request,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [HOSTS-1:0] o_grant
);

    logic [IDX_W-1:0]   start;
    logic [HOSTS-1:0]   rotated;
    logic [2*HOSTS-1:0] picked;
    logic               found;

    always_comb begin
        start = '0;
        if (!FIXED_PRIORITY &&
            (int'(i_last_grant) < (HOSTS - 1))) begin
            start = i_last_grant + IDX_W'(1);
        end
        rotated = HOSTS'({i_request, i_request} >> start);
        picked  = '0;
        found   = 1'b0;
        for (int i = 0; i < HOSTS; i++) begin
            if (!found && rotated[i]) begin
                found                  = 1'b1;
                picked[i + int'(start)] = 1'b1;
            end
        end
        // Fold the upper half back to undo the rotation.
        o_grant = picked[HOSTS-1:0] | picked[2*HOSTS-1:HOSTS];
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one downstream rggen bus between several upstream masters.
// The winner drives the bus in the cycle it wins; grant locks until ready.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter bit FIXED_PRIORITY = 1'b0
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    rggen_bus_if.slave       host_if [HOSTS],
    rggen_bus_if.master      bus_if,
    output logic [HOSTS-1:0] o_grant
);

    localparam int IDX_W  = rggen_clog2_min1(HOSTS);
    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int REQ_W  = 2 + ADDRESS_WIDTH + BUS_WIDTH + STRB_W;

    rggen_arb_state   state;
    rggen_arb_state   state_next;
    logic [IDX_W-1:0] lock;
    logic [IDX_W-1:0] lock_next;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_next;
    logic [IDX_W-1:0] arb_index;
    logic [HOSTS-1:0] request;
    logic [HOSTS-1:0] arb_grant;
    logic [HOSTS-1:0] lock_oh;
    logic [HOSTS-1:0] active;
    logic [HOSTS-1:0] host_ready;
    logic [REQ_W-1:0] req_data [HOSTS];
    logic [REQ_W-1:0] sel_data;

    for (genvar i = 0; i < HOSTS; i++) begin : g_host
        assign request[i]  = host_if[i].valid;
        assign req_data[i] = {
            host_if[i].access,
            host_if[i].address,
            host_if[i].write_data,
            host_if[i].strobe
        };
        assign host_if[i].ready     = host_ready[i];
        assign host_if[i].status    = bus_if.status;
        assign host_if[i].read_data = bus_if.read_data;
    end

    rggen_round_robin_arbiter #(
        .HOSTS          (HOSTS),
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arbiter (
        .i_request    (request),
        .i_last_grant (last_grant),
        .o_grant      (arb_grant)
    );

    always_comb begin
        arb_index = '0;
        lock_oh   = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (arb_grant[i]) begin
                arb_index = IDX_W'(i);
            end
            lock_oh[i] = (lock == IDX_W'(i));
        end
    end

    // Reset gates the grant so nothing reaches the bus mid-reset.
    always_comb begin
        active = '0;
        if (i_rst_n) begin
            active = (state == RGGEN_ARB_BUSY) ? lock_oh : arb_grant;
        end
    end

    assign o_grant    = active;
    assign host_ready = active & {HOSTS{bus_if.ready}};

    rggen_mux #(
        .WIDTH   (REQ_W),
        .ENTRIES (HOSTS)
    ) u_req_mux (
        .i_select (active),
        .i_data   (req_data),
        .o_data   (sel_data)
    );

    assign bus_if.valid      = |(active & request);
    assign bus_if.strobe     = sel_data[STRB_W-1:0];
    assign bus_if.write_data = sel_data[STRB_W+:BUS_WIDTH];
    assign bus_if.address    =
        sel_data[STRB_W+BUS_WIDTH+:ADDRESS_WIDTH];
    assign bus_if.access     =
        rggen_access'(sel_data[REQ_W-1-:2]);

    always_comb begin
        state_next = state;
        lock_next  = lock;
        last_next  = last_grant;
        unique case (state)
            RGGEN_ARB_IDLE: begin
                if (|arb_grant) begin
                    if (bus_if.ready) begin
                        last_next = arb_index;
                    end else begin
                        state_next = RGGEN_ARB_BUSY;
                        lock_next  = arb_index;
                    end
                end
            end
            RGGEN_ARB_BUSY: begin
                if (bus_if.ready) begin
                    state_next = RGGEN_ARB_IDLE;
                    last_next  = lock;
                end
            end
            default: begin
                state_next = RGGEN_ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= RGGEN_ARB_IDLE;
            lock       <= '0;
            last_grant <= IDX_W'(HOSTS - 1);
        end else begin
            state      <= state_next;
            lock       <= lock_next;
            last_grant <= last_next;
        end
    end

`ifdef RGGEN_ENABLE_SVA
    a_grant_onehot0: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant)
    );
    a_ready_onehot0: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(host_ready)
    );
    a_locked_hold: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (state == RGGEN_ARB_BUSY) |-> request[lock]
    );
`endif

endmodule
